// File: rtl/c1908_bist_pkg.sv
// Shared constants and types for the c1908 built-in self-test blocks.
// Holds the FSM state encoding, c1908 port widths, default MISR polynomial
// and seed, and the order in which c1908 outputs are packed into a response
// vector (index 0 = LSB).
package c1908_bist_pkg;

    localparam int unsigned C1908_OUT_W = 25;
    localparam int unsigned C1908_IN_W  = 33;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;

    // Response-compactor FSM states
    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StSettle  = 2'd1;
    localparam state_t StCapture = 2'd2;
    localparam state_t StDone    = 2'd3;

    // c1908 output net numbers in packing order: entry i lands on resp_in[i]
    localparam int unsigned C1908_OUT_NUM [C1908_OUT_W] = '{
        2753, 2754, 2755, 2756, 2762, 2767, 2768, 2779, 2780, 2781,
        2782, 2783, 2784, 2785, 2786, 2787, 2811, 2886, 2887, 2888,
        2889, 2890, 2891, 2892, 2899
    };

    // Bit position of output net PNN<num> in the packed vector, -1 if absent
    function automatic int out_bit_index(int unsigned num);
        int idx;
        idx = -1;
        for (int i = 0; i < int'(C1908_OUT_W); i++) begin
            if (C1908_OUT_NUM[i] == num) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/c1908_resp_misr_if.sv
// Control/response bundle between a c1908 test driver and the response MISR.
// master: drives start, num_vectors, resp_valid, resp_in, golden_sig and
//         observes sig_out, vec_count, busy, done, pass.
// slave:  the MISR side (directions reversed).
interface c1908_resp_misr_if #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned SIG_W = 32
);
    logic             start;
    logic [15:0]      num_vectors;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_in;
    logic [SIG_W-1:0] golden_sig;
    logic [SIG_W-1:0] sig_out;
    logic [15:0]      vec_count;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output start, num_vectors, resp_valid, resp_in, golden_sig,
        input  sig_out, vec_count, busy, done, pass
    );

    modport slave (
        input  start, num_vectors, resp_valid, resp_in, golden_sig,
        output sig_out, vec_count, busy, done, pass
    );
endinterface

// File: rtl/c1908_resp_misr_misr_core.sv
// Multiple-input signature register.
// Ports:
//   clk, reset_n  rising-edge clock, synchronous active-low reset (-> RST_VAL)
//   load/load_val synchronous load of the signature (priority over en)
//   en, din       compact one DIN_W-bit vector (zero-extended to SIG_W)
//   sig           current signature
//   step          value sig would take if en were applied this cycle
module misr_core #(
    parameter int unsigned      SIG_W   = 32,
    parameter int unsigned      DIN_W   = 25,
    parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [SIG_W-1:0] load_val,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] step
);

    logic [SIG_W-1:0] sig_q, sig_d;
    logic [SIG_W-1:0] din_ext;
    logic [SIG_W-1:0] feedback;

    // Upper signature bits see only shift and feedback
    always_comb begin
        din_ext = '0;
        din_ext[DIN_W-1:0] = din;
    end

    always_comb begin
        feedback = sig_q[SIG_W-1] ? POLY : '0;
        step     = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ din_ext;
    end

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = load_val;
        end else if (en) begin
            sig_d = step;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c1908_resp_misr.sv
// Response compactor for the c1908 benchmark wrapper.
// After a start pulse it discards LATENCY cycles, then folds num_vectors
// valid response vectors into a MISR and compares the final signature
// against golden_sig.
// Ports:
//   clk, reset_n  rising-edge clock, synchronous active-low reset
//   bus (slave)   start/num_vectors/resp_valid/resp_in/golden_sig in,
//                 sig_out/vec_count/busy/done/pass out
module c1908_resp_misr
    import c1908_bist_pkg::*;
#(
    parameter int unsigned      WIDTH   = C1908_OUT_W,
    parameter int unsigned      SIG_W   = 32,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEFAULT_SEED),
    parameter int unsigned      LATENCY = 2
) (
    input logic               clk,
    input logic               reset_n,
    c1908_resp_misr_if.slave  bus
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           state_q, state_d;
    logic [15:0]      target_q, target_d;
    logic [15:0]      count_q, count_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             pass_q, pass_d;

    logic             misr_load;
    logic             misr_en;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] step;

    misr_core #(
        .SIG_W   (SIG_W),
        .DIN_W   (WIDTH),
        .POLY    (POLY),
        .RST_VAL (SEED)
    ) u_misr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (misr_load),
        .load_val (SEED),
        .en       (misr_en),
        .din      (bus.resp_in),
        .sig      (sig),
        .step     (step)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        count_d   = count_q;
        settle_d  = settle_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        unique case (state_q)
            // DONE restarts exactly like IDLE
            StIdle, StDone: begin
                if (bus.start) begin
                    target_d  = bus.num_vectors;
                    count_d   = '0;
                    settle_d  = '0;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                    if (bus.num_vectors == 16'd0) begin
                        // Empty run: signature is the seed itself
                        state_d = StDone;
                        pass_d  = (SEED == bus.golden_sig);
                    end else if (LATENCY > 0) begin
                        state_d = StSettle;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end
            StSettle: begin
                settle_d = settle_q + 1'b1;
                if (settle_q == CNT_W'(LATENCY - 1)) begin
                    settle_d = '0;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (bus.resp_valid) begin
                    misr_en = 1'b1;
                    count_d = count_q + 16'd1;
                    if (count_d == target_q) begin
                        state_d = StDone;
                        pass_d  = (step == bus.golden_sig);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            target_q <= '0;
            count_q  <= '0;
            settle_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            count_q  <= count_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.sig_out   = sig;
    assign bus.vec_count = count_q;
    assign bus.busy      = (state_q == StSettle) || (state_q == StCapture);
    assign bus.done      = (state_q == StDone);
    assign bus.pass      = pass_q;

endmodule

// File: tb/tb_c1908_resp_misr.sv
// Bench for c1908_resp_misr: two instances (seed 0 and seed 0x80000000)
// driven identically, checked every cycle against a behavioural model and
// at key points against hand-computed signatures.
module tb_c1908_resp_misr;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam int          LAT  = 2;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    c1908_resp_misr_if #(.WIDTH(25), .SIG_W(32)) i0 ();
    c1908_resp_misr_if #(.WIDTH(25), .SIG_W(32)) i1 ();

    c1908_resp_misr #(
        .WIDTH(25), .SIG_W(32), .POLY(POLY), .SEED(32'h0000_0000), .LATENCY(LAT)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (i0)
    );

    c1908_resp_misr #(
        .WIDTH(25), .SIG_W(32), .POLY(POLY), .SEED(32'h8000_0000), .LATENCY(LAT)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (i1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] seeds [2] = '{32'h0000_0000, 32'h8000_0000};
    logic [31:0] m_sig    [2];
    int          m_count  [2];
    int          m_target [2];
    int          m_wait   [2];
    bit          m_active [2];
    bit          m_done   [2];
    bit          m_pass   [2];

    // Multiply the signature polynomial by x modulo the feedback polynomial
    function automatic logic [31:0] times_x(logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ {1'b1, POLY};
        return t[31:0];
    endfunction

    function automatic logic [24:0] vec(int i);
        logic [24:0] base;
        base = (i % 2 == 1) ? 25'h1555555 : 25'h0AAAAAA;
        return base ^ 25'(i * 37);
    endfunction

    function automatic logic [31:0] sig_of(logic [31:0] seed, int n, logic [24:0] mask);
        logic [31:0] s;
        s = seed;
        for (int i = 0; i < n; i++) s = times_x(s) ^ {7'b0, vec(i) & mask};
        return s;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!reset_n) begin
                    m_sig[k] = seeds[k]; m_count[k] = 0; m_target[k] = 0; m_wait[k] = 0;
                    m_active[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                end else if (!m_active[k] && i0.start) begin
                    m_target[k] = int'(i0.num_vectors);
                    m_count[k] = 0; m_sig[k] = seeds[k]; m_done[k] = 0; m_pass[k] = 0;
                    if (i0.num_vectors == 0) begin
                        m_done[k] = 1; m_pass[k] = (seeds[k] == i0.golden_sig);
                    end else begin
                        m_active[k] = 1; m_wait[k] = LAT;
                    end
                end else if (m_active[k]) begin
                    if (m_wait[k] > 0) begin
                        m_wait[k]--;
                    end else if (i0.resp_valid) begin
                        m_sig[k] = times_x(m_sig[k]) ^ {7'b0, i0.resp_in};
                        m_count[k]++;
                        if (m_count[k] == m_target[k]) begin
                            m_active[k] = 0; m_done[k] = 1;
                            m_pass[k] = (m_sig[k] == i0.golden_sig);
                        end
                    end
                end
            end
        end
    end

    task automatic check(string name, int k, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, k, got, want, $time);
        end
    endtask

    task automatic cmp_dut(int k, logic [31:0] s, logic [15:0] vc, logic b, logic d,
                           logic p);
        check("cyc_sig", k, s, m_sig[k]);
        check("cyc_vec_count", k, 32'(vc), 32'(m_count[k]));
        check("cyc_busy", k, 32'(b), 32'(m_active[k]));
        check("cyc_done", k, 32'(d), 32'(m_done[k]));
        check("cyc_pass", k, 32'(p), 32'(m_pass[k]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp_dut(0, i0.sig_out, i0.vec_count, i0.busy, i0.done, i0.pass);
            cmp_dut(1, i1.sig_out, i1.vec_count, i1.busy, i1.done, i1.pass);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic st, logic [15:0] nv, logic v, logic [24:0] r, logic [31:0] g);
        i0.start = st; i0.num_vectors = nv; i0.resp_valid = v; i0.resp_in = r;
        i0.golden_sig = g;
        i1.start = st; i1.num_vectors = nv; i1.resp_valid = v; i1.resp_in = r;
        i1.golden_sig = g;
    endtask

    task automatic wait_done(int budget);
        int n;
        n = 0;
        while (!i0.done && n < budget) begin
            cyc();
            n++;
        end
        check("wait_done_timeout", 0, 32'(i0.done), 32'd1);
    endtask

    // Start, settle, then feed n toggle vectors with the given bit mask
    task automatic run_vectors(int n, logic [31:0] golden, logic [24:0] mask);
        drive(1, 16'(n), 0, '0, golden); cyc();
        drive(0, 16'(n), 0, '0, golden); cyc(); cyc();
        for (int i = 0; i < n; i++) begin
            drive(0, 16'(n), 1, vec(i) & mask, golden); cyc();
        end
        drive(0, 16'(n), 0, '0, golden);
        wait_done(8);
    endtask

    logic [31:0] exp_sig;
    bit          pat [6] = '{1, 0, 0, 1, 0, 1};

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, '0, '0);
        cyc(); cyc(); cyc();
        check("rst_sig", 0, i0.sig_out, 32'h0);
        check("rst_sig", 1, i1.sig_out, 32'h8000_0000);
        check("rst_busy", 0, 32'(i0.busy), 32'd0);
        reset_n = 1'b1;
        cyc();

        // LSB accumulation
        drive(1, 2, 0, '0, 32'h3); cyc();
        drive(0, 2, 0, '0, 32'h3); cyc(); cyc();
        check("t2_busy_settled", 0, 32'(i0.busy), 32'd1);
        drive(0, 2, 1, 25'h1, 32'h3); cyc();
        check("t2_done_early", 0, 32'(i0.done), 32'd0);
        cyc();
        drive(0, 2, 0, '0, 32'h3);
        check("t2_sig", 0, i0.sig_out, 32'h3);
        check("t2_sig", 1, i1.sig_out, 32'h0982_3B6D);
        check("t2_vec_count", 0, 32'(i0.vec_count), 32'd2);
        check("t2_done", 0, 32'(i0.done), 32'd1);
        check("t2_pass", 0, 32'(i0.pass), 32'd1);
        check("t2_pass", 1, 32'(i1.pass), 32'd0);

        // Feedback tap
        drive(1, 1, 0, '0, 32'h0); cyc();
        drive(0, 1, 0, '0, 32'h0); cyc(); cyc();
        drive(0, 1, 1, '0, 32'h0); cyc();
        drive(0, 1, 0, '0, 32'h0);
        check("t3_sig", 1, i1.sig_out, 32'h04C1_1DB7);
        check("t3_pass", 1, 32'(i1.pass), 32'd0);
        check("t3_pass", 0, 32'(i0.pass), 32'd1);

        // Valid gaps
        drive(1, 3, 0, '0, 32'h0); cyc();
        drive(0, 3, 0, '0, 32'h0); cyc(); cyc();
        for (int i = 0; i < 6; i++) begin
            drive(0, 3, pat[i], 25'h1FFFFFF, 32'h0); cyc();
            if (i == 2) check("t4_stall_sig", 0, i0.sig_out, 32'h01FF_FFFF);
            if (i == 4) check("t4_done_early", 0, 32'(i0.done), 32'd0);
        end
        drive(0, 3, 0, '0, 32'h0);
        check("t4_done", 0, 32'(i0.done), 32'd1);
        check("t4_vec_count", 0, 32'(i0.vec_count), 32'd3);
        check("t4_sig", 0, i0.sig_out, 32'h05FF_FFFD);

        // Zero-length run
        drive(1, 0, 0, '0, 32'h0); cyc();
        drive(0, 0, 0, '0, 32'h0);
        check("t5_zero_done", 0, 32'(i0.done), 32'd1);
        check("t5_zero_sig", 1, i1.sig_out, 32'h8000_0000);
        check("t5_zero_pass", 0, 32'(i0.pass), 32'd1);
        check("t5_zero_pass", 1, 32'(i1.pass), 32'd0);

        // start during SETTLE is ignored
        drive(1, 2, 0, '0, 32'h0); cyc();
        drive(1, 5, 0, '0, 32'h0); cyc();
        drive(0, 5, 0, '0, 32'h0); cyc();
        drive(0, 5, 1, 25'h1, 32'h0); cyc(); cyc();
        drive(0, 5, 0, '0, 32'h0);
        check("t5_ign_done", 0, 32'(i0.done), 32'd1);
        check("t5_ign_vec_count", 0, 32'(i0.vec_count), 32'd2);

        // Reset mid-capture
        drive(1, 10, 0, '0, 32'h0); cyc();
        drive(0, 10, 0, '0, 32'h0); cyc(); cyc();
        drive(0, 10, 1, 25'h5, 32'h0); cyc(); cyc(); cyc();
        reset_n = 1'b0; cyc(); cyc();
        drive(0, 10, 0, '0, 32'h0);
        check("t1_sig", 0, i0.sig_out, 32'h0);
        check("t1_vec_count", 0, 32'(i0.vec_count), 32'd0);
        check("t1_busy", 0, 32'(i0.busy), 32'd0);
        check("t1_done", 0, 32'(i0.done), 32'd0);
        check("t1_pass", 0, 32'(i0.pass), 32'd0);
        reset_n = 1'b1; cyc();

        // End-to-end: 64 vectors twice from reset, then stuck-at-0 on bit 3
        exp_sig = sig_of(32'h0, 64, '1);
        for (int r = 0; r < 2; r++) begin
            run_vectors(64, exp_sig, '1);
            check("t6_sig", 0, i0.sig_out, exp_sig);
            check("t6_pass", 0, 32'(i0.pass), 32'd1);
            reset_n = 1'b0; cyc(); reset_n = 1'b1; cyc();
        end
        run_vectors(64, exp_sig, ~25'h8);
        check("t6_stuck_pass", 0, 32'(i0.pass), 32'd0);
        check("t6_stuck_sig", 0, i0.sig_out, sig_of(32'h0, 64, ~25'h8));

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
